// File: rtl/ext_sram_bridge_pkg.sv
// ext_sram_bridge_pkg
//   Shared constants for the external SRAM bridge: FSM state encodings and
//   byte-lane identifiers. Imported by ext_sram_bridge and sram_byte_cycle.
package ext_sram_bridge_pkg;

  // BR_SETUP/BR_STROBE/BR_HOLD are the byte-phase states inside
  // sram_byte_cycle. The top level uses BR_SETUP to mean "byte phases in
  // flight" and never enters BR_STROBE or BR_HOLD itself.
  typedef enum logic [2:0] {
    BR_IDLE   = 3'd0,
    BR_SETUP  = 3'd1,
    BR_STROBE = 3'd2,
    BR_HOLD   = 3'd3,
    BR_DONE   = 3'd4
  } br_state_t;

  // Byte lanes of a 16-bit word: lane 0 is data[7:0] at byte address addr*2.
  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  // Width of the strobe wait counter (WAIT_CYCLES is 1..15).
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/ext_sram_bridge_sram_byte_cycle.sv
// sram_byte_cycle
//   Runs one byte access on an asynchronous 8-bit SRAM:
//   SETUP (1 cycle) -> STROBE (WAIT_CYCLES cycles) -> HOLD (writes only).
//   All SRAM pins are registered so strobes are glitch-free.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin a phase; accepted when idle or in the phase_done cycle
//   wr              1 = write phase, 0 = read phase (captured on start)
//   byte_addr       SRAM byte address (captured on start)
//   wr_byte         write data (captured on start)
//   busy            a phase is in progress
//   phase_done      one-cycle pulse in the final cycle of the phase
//   rd_byte         read byte; valid while phase_done is high on a read
//   sram_*          SRAM pad signals
module sram_byte_cycle
  import ext_sram_bridge_pkg::*;
#(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 wr,
  input  logic [ADDR_BITS:0]   byte_addr,
  input  logic [7:0]           wr_byte,
  output logic                 busy,
  output logic                 phase_done,
  output logic [7:0]           rd_byte,
  output logic [ADDR_BITS:0]   sram_addr,
  output logic [7:0]           sram_dq_out,
  input  logic [7:0]           sram_dq_in,
  output logic                 sram_dq_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_CYCLES - 1);

  br_state_t              state_reg, state_next;
  logic [WAIT_CNT_W-1:0]  cnt_reg, cnt_next;
  logic                   wr_reg, wr_next;
  logic [ADDR_BITS:0]     addr_reg, addr_next;
  logic [7:0]             data_reg, data_next;
  logic                   accept;
  logic                   ce_n_reg, oe_n_reg, we_n_reg, dq_oe_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= BR_IDLE;
      cnt_reg   <= '0;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      ce_n_reg  <= 1'b1;
      oe_n_reg  <= 1'b1;
      we_n_reg  <= 1'b1;
      dq_oe_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wr_reg    <= wr_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      // Pins follow the state being entered, so they change exactly on the
      // state edge and a reset clears them at the very next edge.
      ce_n_reg  <= (state_next == BR_IDLE);
      oe_n_reg  <= !((state_next == BR_STROBE) && !wr_next);
      we_n_reg  <= !((state_next == BR_STROBE) && wr_next);
      dq_oe_reg <= wr_next && (state_next != BR_IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_next    = wr_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    phase_done = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      BR_IDLE: accept = start;
      BR_SETUP: begin
        state_next = BR_STROBE;
        cnt_next   = '0;
      end
      BR_STROBE: begin
        if (cnt_reg == LAST_CNT) begin
          if (wr_reg) begin
            state_next = BR_HOLD;
          end else begin
            // Last strobe cycle of a read: the pad data is sampled here.
            phase_done = 1'b1;
            accept     = start;
            state_next = BR_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      BR_HOLD: begin
        phase_done = 1'b1;
        accept     = start;
        state_next = BR_IDLE;
      end
      default: state_next = BR_IDLE;
    endcase
    // A start in the phase_done cycle chains straight into the next SETUP.
    if (accept) begin
      state_next = BR_SETUP;
      wr_next    = wr;
      addr_next  = byte_addr;
      data_next  = wr_byte;
    end
  end

  assign busy        = (state_reg != BR_IDLE);
  assign rd_byte     = sram_dq_in;
  assign sram_addr   = addr_reg;
  assign sram_dq_out = data_reg;
  assign sram_dq_oe  = dq_oe_reg;
  assign sram_ce_n   = ce_n_reg;
  assign sram_oe_n   = oe_n_reg;
  assign sram_we_n   = we_n_reg;

endmodule

// File: rtl/ext_sram_bridge.sv
// ext_sram_bridge
//   Memory-bus responder mapping a word-address window onto an external
//   asynchronous 8-bit SRAM. Word accesses run two byte phases (lane 0 then
//   lane 1); byte accesses run one. mem_wait stalls the core until done.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   en, write_enable             bus request strobe, 1 = write
//   byte_enable, byte_select     single-byte access, lane (1 = high byte)
//   addr, data_in                word address, write data
//   data_out, serviced_read      registered read data, valid-read flag
//   mem_wait                     stall request (combinational)
//   sram_*                       SRAM pad signals
module ext_sram_bridge
  import ext_sram_bridge_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h2000,
  parameter int          ADDR_BITS   = 12,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 write_enable,
  input  logic                 byte_enable,
  input  logic                 byte_select,
  input  logic [15:0]          addr,
  input  logic [15:0]          data_in,
  output logic [15:0]          data_out,
  output logic                 serviced_read,
  output logic                 mem_wait,
  output logic [ADDR_BITS:0]   sram_addr,
  output logic [7:0]           sram_dq_out,
  input  logic [7:0]           sram_dq_in,
  output logic                 sram_dq_oe,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  br_state_t               state_reg, state_next;
  logic                    consumed_reg, consumed_next;
  logic                    wr_reg, wr_next;
  logic                    byte_reg, byte_next;
  logic                    lane_reg, lane_next;
  logic [ADDR_BITS-1:0]    off_reg, off_next;
  logic [15:0]             wdata_reg, wdata_next;
  logic [7:0]              lo_byte_reg, lo_byte_next;
  logic [15:0]             data_out_reg, data_out_next;
  logic                    serviced_reg, serviced_next;

  logic                    hit, take, first_lane;
  logic                    ph_start, ph_wr, ph_busy, ph_done;
  logic [ADDR_BITS:0]      ph_addr;
  logic [7:0]              ph_wbyte, ph_rbyte;

  assign hit  = (addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
  assign take = en && hit && (state_reg == BR_IDLE) && !consumed_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= BR_IDLE;
      consumed_reg <= 1'b0;
      wr_reg       <= 1'b0;
      byte_reg     <= 1'b0;
      lane_reg     <= LANE_LO;
      off_reg      <= '0;
      wdata_reg    <= '0;
      lo_byte_reg  <= '0;
      data_out_reg <= '0;
      serviced_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      consumed_reg <= consumed_next;
      wr_reg       <= wr_next;
      byte_reg     <= byte_next;
      lane_reg     <= lane_next;
      off_reg      <= off_next;
      wdata_reg    <= wdata_next;
      lo_byte_reg  <= lo_byte_next;
      data_out_reg <= data_out_next;
      serviced_reg <= serviced_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wr_next       = wr_reg;
    byte_next     = byte_reg;
    lane_next     = lane_reg;
    off_next      = off_reg;
    wdata_next    = wdata_reg;
    lo_byte_next  = lo_byte_reg;
    data_out_next = data_out_reg;
    first_lane    = byte_enable ? byte_select : LANE_LO;
    // Default phase request is the second (high) lane of the captured word.
    ph_start      = 1'b0;
    ph_wr         = wr_reg;
    ph_addr       = {off_reg, LANE_HI};
    ph_wbyte      = wdata_reg[15:8];
    case (state_reg)
      BR_IDLE: begin
        if (take) begin
          // Request inputs are used live only in this cycle, then captured.
          ph_start   = 1'b1;
          ph_wr      = write_enable;
          ph_addr    = {addr[ADDR_BITS-1:0], first_lane};
          ph_wbyte   = data_in[7:0];
          wr_next    = write_enable;
          byte_next  = byte_enable;
          lane_next  = first_lane;
          off_next   = addr[ADDR_BITS-1:0];
          wdata_next = data_in;
          state_next = BR_SETUP;
        end
      end
      BR_SETUP: begin
        if (ph_done) begin
          if (!byte_reg && (lane_reg == LANE_LO)) begin
            ph_start     = 1'b1;
            lane_next    = LANE_HI;
            lo_byte_next = ph_rbyte;
          end else begin
            state_next = BR_DONE;
            if (!wr_reg) begin
              data_out_next = byte_reg ? {ph_rbyte, ph_rbyte} : {ph_rbyte, lo_byte_reg};
            end
          end
        end
      end
      BR_DONE: state_next = BR_IDLE;
      default: state_next = BR_IDLE;
    endcase
  end

  // consumed blocks a held en from retriggering; any en=0 cycle re-arms.
  always_comb begin
    consumed_next = consumed_reg;
    if (!en) begin
      consumed_next = 1'b0;
    end else if (state_next == BR_DONE) begin
      consumed_next = 1'b1;
    end
  end

  // Setting on DONE entry takes priority over the clear by a live request.
  always_comb begin
    serviced_next = serviced_reg;
    if ((state_reg == BR_SETUP) && (state_next == BR_DONE)) begin
      serviced_next = !wr_reg;
    end else if (en && !consumed_reg) begin
      serviced_next = 1'b0;
    end
  end

  assign mem_wait      = take || (state_reg == BR_SETUP);
  assign data_out      = data_out_reg;
  assign serviced_read = serviced_reg;

  sram_byte_cycle #(
    .ADDR_BITS   (ADDR_BITS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_byte_cycle (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (ph_start),
    .wr          (ph_wr),
    .byte_addr   (ph_addr),
    .wr_byte     (ph_wbyte),
    .busy        (ph_busy),
    .phase_done  (ph_done),
    .rd_byte     (ph_rbyte),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n)
  );

  // ph_busy mirrors state_reg == BR_SETUP; kept for visibility in waves.
  logic unused_ok;
  assign unused_ok = ph_busy;

endmodule
